bs_mul_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one es_ordered_bs_mul instance among NUM_REQ requesters.
- Each request carries a full operand set.
- The scheduler:
  - arbitrates between pending requests;
  - captures the winner's operands;
  - clears and runs the multiplier until done;
  - returns the result tagged with the requester ID over a valid/ready response port.
- Sits between the DSC arch-sweep requester logic and the multiplier core.

---
 rtl/bs_sched_pkg.sv | 42 ++++
 rtl/bs_rr_arbiter.sv | 28 ++
 rtl/bs_mul_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_bs_mul_rr_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler: FSM state
// encoding, the rotating-priority pick function and result-width derivation.
package bs_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // The pick function works on a fixed-size vector so it can serve any NUM_REQ up to this bound.
    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_REQ-1:0]   onehot;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    function automatic int res_width(input int dw, input int ni);
        return dw * ni;
    endfunction

    // First valid requester searching upward from ptr+1, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        pick_t p;
        int    cand;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (ptr + k) % n;
            if (!p.found && k <= n && valid[cand[MAX_IDX_W-1:0]]) begin
                p.found                         = 1'b1;
                p.idx                           = cand[MAX_IDX_W-1:0];
                p.onehot[cand[MAX_IDX_W-1:0]]   = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant and index of the first valid
// requester after ptr. Zero latency, no state.
module bs_rr_arbiter
    import bs_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    pick_t pick;
    logic  unused_pick;

    always_comb begin
        pick = rr_pick(MAX_REQ'(valid), int'(ptr), NUM_REQ);
    end

    assign grant       = pick.onehot[NUM_REQ-1:0];
    assign grant_id    = pick.idx[ID_W-1:0];
    assign grant_vld   = pick.found;
    assign unused_pick = ^{pick.onehot[MAX_REQ-1:NUM_REQ], pick.idx[MAX_IDX_W-1:ID_W]};

endmodule

// File: rtl/bs_mul_rr_scheduler.sv
// Round-robin scheduler sharing one bit-serial multiplier among NUM_REQ requesters.
// Optional watchdog on the RUN state is built when BS_SCHED_TIMEOUT_EN is defined.
module bs_mul_rr_scheduler
    import bs_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_REQ     = 4,
    parameter int RES_WIDTH   = res_width(DATA_WIDTH, NUM_INPUTS),
    parameter int TIMEOUT_CYC = 2**(DATA_WIDTH*NUM_INPUTS) + 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
    output logic [RES_WIDTH-1:0]                   rsp_data,
    output logic                                   rsp_err,
    output logic                                   mul_clr,
    output logic                                   mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]       mul_data,
    input  logic [RES_WIDTH-1:0]                   mul_result,
    input  logic                                   mul_done,
    output logic                                   busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int OPW  = NUM_INPUTS * DATA_WIDTH;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_vld;
    logic [OPW-1:0]   sel_data;
    logic             accept;

    bs_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) sel_data = req_data[i*OPW +: OPW];
        end
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = (state == IDLE) && grant_vld;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef BS_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign rsp_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYC;

    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            rsp_id   <= '0;
            rsp_data <= '0;
            mul_clr  <= 1'b0;
            mul_en   <= 1'b0;
            mul_data <= '0;
`ifdef BS_SCHED_TIMEOUT_EN
            wd_cnt   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            mul_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_data <= sel_data;
                        rsp_id   <= grant_id;
                        mul_clr  <= 1'b1;
                        state    <= CLR;
`ifdef BS_SCHED_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                CLR: begin
                    mul_en <= 1'b1;
                    state  <= RUN;
`ifdef BS_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                RUN: begin
                    if (mul_done) begin
                        rsp_data <= mul_result;
                        mul_en   <= 1'b0;
                        state    <= RESP;
                    end
`ifdef BS_SCHED_TIMEOUT_EN
                    // Give up after TIMEOUT_CYC RUN cycles and reset the multiplier on the way out.
                    else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data <= '0;
                        err_q    <= 1'b1;
                        mul_en   <= 1'b0;
                        mul_clr  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= rsp_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_mul_rr_scheduler.sv
// Directed bench for bs_mul_rr_scheduler with an 8-cycle behavioural multiplier.
module tb_bs_mul_rr_scheduler;

    localparam int DW  = 5;
    localparam int NI  = 2;
    localparam int NR  = 4;
    localparam int RW  = DW * NI;
    localparam int OPW = DW * NI;
    localparam int TO  = 2**(DW*NI) + 16;
    localparam int L   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*OPW-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic              mul_clr;
    logic              mul_en;
    logic [OPW-1:0]    mul_data;
    logic [RW-1:0]     mul_result;
    logic              mul_done;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bs_mul_rr_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .NUM_REQ    (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mul_clr    (mul_clr),
        .mul_en     (mul_en),
        .mul_data   (mul_data),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .busy       (busy)
    );

    // Multiplier model: done on the L-th enabled cycle after a clear.
    logic [4:0] mcnt;
    logic       suppress;

    always @(posedge clk) begin
        if (mul_clr) mcnt <= '0;
        else if (mul_en && mcnt != 5'd31) mcnt <= mcnt + 5'd1;
    end

    assign mul_done   = mul_en && (mcnt == 5'(L - 1)) && !suppress;
    assign mul_result = RW'(mul_data[4:0]) * RW'(mul_data[9:5]);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int r, input int a, input int b);
        req_data[r*OPW +: OPW] = {5'(b), 5'(a)};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Raise one request, hold it until granted, then drop it (ends at negedge of T+1).
    task automatic grant_one(input int r, output bit ok);
        int n;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 50) begin
            tick();
            #1;
            n++;
        end
        ok = req_ready[r];
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({mul_clr, mul_en} !== 2'b00) begin failures++; $display("FAIL reset_mul_ctl got=%b exp=00", {mul_clr, mul_en}); end
        checks++; if ({rsp_id, rsp_data, rsp_err, mul_data} !== '0) begin failures++; $display("FAIL reset_regs id=%0d data=%0d err=%b mdata=%0d exp=all0", rsp_id, rsp_data, rsp_err, mul_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        set_op(2, 16, 16);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if ({req_ready, mul_clr, mul_en, busy} !== 7'b0000_101) begin failures++; $display("FAIL single_clr got=%b exp=0000101", {req_ready, mul_clr, mul_en, busy}); end
        wait_rsp(60, n);
        checks++; if (n + 1 !== 10) begin failures++; $display("FAIL single_latency got=%0d exp=10", n + 1); end
        checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
        checks++; if (rsp_data !== 10'd256) begin failures++; $display("FAIL single_data got=%0d exp=256", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", rsp_err); end
        tick();
        checks++; if ({busy, rsp_valid} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {busy, rsp_valid}); end
    endtask

    task automatic run_round(input bit hold);
        int k;
        int cyc;
        logic [NR-1:0] pend;
        for (int i = 0; i < NR; i++) set_op(i, i + 1, 3);
        req_valid = 4'hf;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 400) begin
            #1;
            pend = req_valid & req_ready;
            if (rsp_valid) begin
                checks++; if (rsp_id !== 2'(k)) begin failures++; $display("FAIL rr_order hold=%0d got=%0d exp=%0d", hold, rsp_id, k); end
                checks++; if (rsp_data !== 10'(3 * (k + 1))) begin failures++; $display("FAIL rr_data hold=%0d got=%0d exp=%0d", hold, rsp_data, 3 * (k + 1)); end
                k++;
                if (hold && k == 4) req_valid = 4'h0;
            end
            tick();
            cyc++;
            if (!hold) req_valid = req_valid & ~pend;
        end
        checks++; if (k !== 4) begin failures++; $display("FAIL rr_count hold=%0d got=%0d exp=4", hold, k); end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_all_requesters();
        do_reset();
        run_round(1'b0);
        run_round(1'b1);
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int bad;
        rsp_ready = 1'b0;
        set_op(1, 5, 7);
        set_op(3, 2, 2);
        grant_one(1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_grant got=%b exp=1", ok); end
        req_valid[3] = 1'b1;
        wait_rsp(60, n);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, 2'd1, 10'd35, 4'b0000, 1'b1}) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 id=%0d data=%0d", bad, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        #1;
        checks++; if ({busy, rsp_valid, req_ready} !== {1'b0, 1'b0, 4'b1000}) begin failures++; $display("FAIL bp_release got=%b exp=001000", {busy, rsp_valid, req_ready}); end
        req_valid = 4'h0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_withdraw busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        set_op(0, 3, 4);
        grant_one(0, ok);
        tick();
        tick();
        tick();
        tick();
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL mid_running mul_en=%b exp=1", mul_en); end
        rst = 1'b1;
        #1;
        checks++; if ({mul_en, busy, rsp_valid} !== 3'b000) begin failures++; $display("FAIL mid_reset got=%b exp=000", {mul_en, busy, rsp_valid}); end
        tick();
        rst = 1'b0;
        tick();
        set_op(0, 7, 9);
        grant_one(0, ok);
        wait_rsp(60, n);
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 10'd63}) begin failures++; $display("FAIL mid_after v=%b id=%0d data=%0d exp=1/0/63", rsp_valid, rsp_id, rsp_data); end
        tick();
    endtask

`ifdef BS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        suppress = 1'b1;
        set_op(2, 2, 3);
        grant_one(2, ok);
        wait_rsp(TO + 60, n);
        checks++; if (n + 1 !== TO + 2) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", n + 1, TO + 2); end
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 10'd0}) begin failures++; $display("FAIL to_resp v=%b err=%b data=%0d exp=1/1/0", rsp_valid, rsp_err, rsp_data); end
        checks++; if (mul_clr !== 1'b1) begin failures++; $display("FAIL to_clr_pulse got=%b exp=1", mul_clr); end
        tick();
        checks++; if (mul_clr !== 1'b0) begin failures++; $display("FAIL to_clr_end got=%b exp=0", mul_clr); end
        suppress = 1'b0;
        set_op(2, 4, 6);
        grant_one(2, ok);
        wait_rsp(60, n);
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 10'd24}) begin failures++; $display("FAIL to_recover v=%b err=%b data=%0d exp=1/0/24", rsp_valid, rsp_err, rsp_data); end
        tick();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        suppress  = 1'b0;
        test_reset();
        test_single();
        test_all_requesters();
        test_backpressure();
        test_reset_mid();
`ifdef BS_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
